// File: rtl/cam_types_pkg.sv
// Shared types and constants for the CAM checker.
package cam_types_pkg;

    // Checker FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone,
        StTmo
    } ckr_state_e;

    localparam int unsigned CAM_VAL_W = 16;
    localparam int unsigned TMO_CNT_W = 32;

    // Expected read response, sized for the default value width.
    typedef struct packed {
        logic                 hit;
        logic [CAM_VAL_W-1:0] val;
    } cam_exp_t;

endpackage

// File: rtl/cam_shadow_model.sv
// Shadow key/value store mirroring the CAM contents and replacement policy.
// Lookup is combinational on the current (pre-update) state.
module cam_shadow_model #(
    parameter int unsigned KEY_W   = 16,
    parameter int unsigned VAL_W   = 16,
    parameter int unsigned DEPTH_P = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [KEY_W-1:0] key,
    input  logic [VAL_W-1:0] wr_val,
    output logic             hit,
    output logic [VAL_W-1:0] rd_val
);

    localparam int unsigned IDX_W = $clog2(DEPTH_P);

    logic [DEPTH_P-1:0] vld_q;
    logic [KEY_W-1:0]   key_q [DEPTH_P];
    logic [VAL_W-1:0]   val_q [DEPTH_P];
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;

    logic               free;
    logic [IDX_W-1:0]   hit_idx;
    logic [IDX_W-1:0]   free_idx;
    logic [IDX_W-1:0]   victim;

    // Key match and lowest free slot; descending loops leave the lowest index.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        rd_val   = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = int'(DEPTH_P) - 1; i >= 0; i--) begin
            if (vld_q[i] && (key_q[i] == key)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
                rd_val  = val_q[i];
            end
            if (!vld_q[i]) begin
                free     = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    // Slot chosen for a write and round-robin pointer advance (explicit wrap).
    always_comb begin
        victim = hit ? hit_idx : (free ? free_idx : ptr_q);
        ptr_d  = (ptr_q == IDX_W'(DEPTH_P - 1)) ? '0 : ptr_q + 1'b1;
    end

    // Valid bits and pointer; pointer moves only when a full model evicts.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            ptr_q <= '0;
        end else if (wr_en) begin
            vld_q[victim] <= 1'b1;
            if (!hit && !free) begin
                ptr_q <= ptr_d;
            end
        end
    end

    // Entry payload; meaningless while the matching valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            key_q[victim] <= key;
            val_q[victim] <= wr_val;
        end
    end

endmodule

// File: rtl/cam_checker.sv
// Run-time CAM checker: shadow model, fixed-latency compare, error/check
// counters, watchdog and sticky pass/fail verdict.
module cam_checker
    import cam_types_pkg::*;
#(
    parameter int unsigned KEY_W       = 16,
    parameter int unsigned VAL_W       = 16,
    parameter int unsigned DEPTH_P     = 8,
    parameter int unsigned READ_LAT_P  = 1,
    parameter int unsigned TIMEOUT_P   = 10000,
    parameter int unsigned IDLE_MODE_P = 0,
    parameter int unsigned ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mon_valid,
    input  logic             mon_rw_n,
    input  logic [KEY_W-1:0] mon_key,
    input  logic [VAL_W-1:0] mon_val,
    input  logic             dut_valid,
    input  logic [VAL_W-1:0] dut_val,
    input  logic             done_i,
    output logic             err_pulse_o,
    output logic [ERR_W-1:0] err_cnt_o,
    output logic [15:0]      chk_cnt_o,
    output logic             timeout_o,
    output logic             pass_o,
    output logic             fail_o
);

    ckr_state_e state_q, state_d;

    logic                 accept, rd_push, wr_en;
    logic                 exp_hit;
    logic [VAL_W-1:0]     exp_val;
    logic [READ_LAT_P-1:0] pv_q;
    logic [READ_LAT_P-1:0] ph_q;
    logic [VAL_W-1:0]     pval_q [READ_LAT_P];
    logic                 ex_vld, mismatch, busy_next, expired;
    logic [ERR_W-1:0]     err_q, err_d;
    logic [15:0]          chk_q, chk_d;
    logic [TMO_CNT_W-1:0] tmr_q, tmr_d;
    logic                 pass_q, pass_d, fail_q, fail_d;

    // Requests are live only before a terminal state is reached.
    assign accept  = mon_valid && ((state_q == StIdle) || (state_q == StRun));
    assign rd_push = accept && mon_rw_n;
    assign wr_en   = accept && !mon_rw_n;

    cam_shadow_model #(
        .KEY_W  (KEY_W),
        .VAL_W  (VAL_W),
        .DEPTH_P(DEPTH_P)
    ) u_model (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .key   (mon_key),
        .wr_val(mon_val),
        .hit   (exp_hit),
        .rd_val(exp_val)
    );

    // Pipeline exit, compare and watchdog expiry.
    always_comb begin
        ex_vld    = pv_q[READ_LAT_P-1];
        mismatch  = ex_vld && ((dut_valid != ph_q[READ_LAT_P-1]) ||
                               (ph_q[READ_LAT_P-1] && (dut_val != pval_q[READ_LAT_P-1])));
        // Compares still pending after this edge (the exit stage drains now).
        busy_next = rd_push;
        for (int i = 0; i < int'(READ_LAT_P) - 1; i++) begin
            busy_next = busy_next | pv_q[i];
        end
        expired   = (state_q == StRun) && (tmr_q == TMO_CNT_W'(TIMEOUT_P - 1)) &&
                    !((IDLE_MODE_P == 1) && mon_valid);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next state; done_i loses to expiry only when compares are in flight.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (mon_valid) state_d = StRun;
            StRun: begin
                if (done_i && !(expired && (|pv_q))) state_d = StDone;
                else if (expired)                     state_d = StTmo;
            end
            StDone: state_d = StDone;
            StTmo:  state_d = StTmo;
        endcase
    end

    // FSM-derived and compare outputs.
    always_comb begin
        err_pulse_o = mismatch;
        timeout_o   = (state_q == StTmo);
        err_cnt_o   = err_q;
        chk_cnt_o   = chk_q;
        pass_o      = pass_q;
        fail_o      = fail_q;
    end

    // Counter, timer and verdict next-state.
    always_comb begin
        err_d = err_q;
        if (mismatch && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
        chk_d = chk_q + 16'(ex_vld);

        tmr_d = tmr_q;
        if (state_q == StIdle) begin
            tmr_d = '0;
        end else if (state_q == StRun) begin
            if ((IDLE_MODE_P == 1) && mon_valid) tmr_d = '0;
            else                                 tmr_d = tmr_q + 1'b1;
        end

        pass_d = pass_q;
        fail_d = fail_q;
        if (!pass_q && !fail_q) begin
            if ((state_d == StDone) && !busy_next) begin
                pass_d = (err_d == '0);
                fail_d = (err_d != '0);
            end else if (state_d == StTmo) begin
                fail_d = 1'b1;
            end
        end
    end

    // Counters, timer and sticky verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q  <= '0;
            chk_q  <= '0;
            tmr_q  <= '0;
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            err_q  <= err_d;
            chk_q  <= chk_d;
            tmr_q  <= tmr_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
        end
    end

    // Compare pipeline valid bits; reset flushes in-flight compares.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
        end else begin
            pv_q[0] <= rd_push;
            for (int i = 1; i < int'(READ_LAT_P); i++) pv_q[i] <= pv_q[i-1];
        end
    end

    // Compare pipeline payload.
    always_ff @(posedge clk) begin
        ph_q[0]   <= exp_hit;
        pval_q[0] <= exp_val;
        for (int i = 1; i < int'(READ_LAT_P); i++) begin
            ph_q[i]   <= ph_q[i-1];
            pval_q[i] <= pval_q[i-1];
        end
    end

endmodule

// File: tb/tb_cam_checker.sv
// Directed bench for cam_checker: instance A (depth 4, latency 1, 2-bit
// error counter, idle-based 20-cycle watchdog) and instance B (latency 3).
module tb_cam_checker;

    logic        clk;
    logic        rst;
    logic        mon_valid;
    logic        mon_rw_n;
    logic [15:0] mon_key;
    logic [15:0] mon_val;
    logic        done_i;
    logic        dv_a, dv_b;
    logic [15:0] dval_a, dval_b;

    logic        pulse_a, tmo_a, pass_a, fail_a;
    logic [1:0]  err_a;
    logic [15:0] chk_a;
    logic        pulse_b, tmo_b, pass_b, fail_b;
    logic [7:0]  err_b;
    logic [15:0] chk_b;

    int n_checks = 0;
    int n_fail   = 0;

    cam_checker #(
        .KEY_W(16), .VAL_W(16), .DEPTH_P(4), .READ_LAT_P(1),
        .TIMEOUT_P(20), .IDLE_MODE_P(1), .ERR_W(2)
    ) u_dut_a (
        .clk(clk), .rst(rst), .mon_valid(mon_valid), .mon_rw_n(mon_rw_n),
        .mon_key(mon_key), .mon_val(mon_val), .dut_valid(dv_a), .dut_val(dval_a),
        .done_i(done_i), .err_pulse_o(pulse_a), .err_cnt_o(err_a), .chk_cnt_o(chk_a),
        .timeout_o(tmo_a), .pass_o(pass_a), .fail_o(fail_a)
    );

    cam_checker #(
        .KEY_W(16), .VAL_W(16), .DEPTH_P(4), .READ_LAT_P(3),
        .TIMEOUT_P(1000), .IDLE_MODE_P(0), .ERR_W(8)
    ) u_dut_b (
        .clk(clk), .rst(rst), .mon_valid(mon_valid), .mon_rw_n(mon_rw_n),
        .mon_key(mon_key), .mon_val(mon_val), .dut_valid(dv_b), .dut_val(dval_b),
        .done_i(done_i), .err_pulse_o(pulse_b), .err_cnt_o(err_b), .chk_cnt_o(chk_b),
        .timeout_o(tmo_b), .pass_o(pass_b), .fail_o(fail_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; mon_valid = 1'b0; done_i = 1'b0;
        dv_a = 1'b0; dval_a = '0; dv_b = 1'b0; dval_b = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic req(input logic rw, input logic [15:0] k, input logic [15:0] v);
        mon_valid = 1'b1; mon_rw_n = rw; mon_key = k; mon_val = v;
        tick();
        mon_valid = 1'b0;
    endtask

    // Read on instance A; the DUT answer is presented one cycle later.
    task automatic read_a(input string tag, input logic [15:0] k, input logic h,
                          input logic [15:0] v, input logic exp_pulse);
        req(1'b1, k, 16'h0);
        dv_a = h; dval_a = v;
        #1;
        check_eq(tag, 32'(pulse_a), 32'(exp_pulse));
        tick();
        dv_a = 1'b0; dval_a = '0;
    endtask

    task automatic pulse_done();
        done_i = 1'b1;
        tick();
        done_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "bench watchdog");
    end

    initial begin
        mon_rw_n = 1'b0; mon_key = '0; mon_val = '0;
        do_reset();

        // Test 1: basic hit, pass verdict.
        check_eq("rst_err",   32'(err_a),   0);
        check_eq("rst_chk",   32'(chk_a),   0);
        check_eq("rst_tmo",   32'(tmo_a),   0);
        check_eq("rst_pass",  32'(pass_a),  0);
        check_eq("rst_fail",  32'(fail_a),  0);
        check_eq("rst_pulse", 32'(pulse_a), 0);
        req(1'b0, 16'd1, 16'h000A);
        req(1'b0, 16'd2, 16'h000B);
        read_a("t1_rd2", 16'd2, 1'b1, 16'h000B, 1'b0);
        check_eq("t1_chk", 32'(chk_a), 1);
        check_eq("t1_err", 32'(err_a), 0);
        pulse_done();
        check_eq("t1_pass", 32'(pass_a), 1);
        check_eq("t1_fail", 32'(fail_a), 0);

        // Test 2: eviction on full model, miss expected, DUT claims hit.
        do_reset();
        for (int i = 1; i <= 4; i++) req(1'b0, 16'(i), 16'(i * 16'h11));
        req(1'b0, 16'd5, 16'h0055);
        read_a("t2_rd1_evicted", 16'd1, 1'b1, 16'h0011, 1'b1);
        check_eq("t2_err", 32'(err_a), 1);
        read_a("t2_rd5", 16'd5, 1'b1, 16'h0055, 1'b0);
        read_a("t2_rd2", 16'd2, 1'b1, 16'h0022, 1'b0);
        req(1'b0, 16'd6, 16'h0066);
        read_a("t2_rd2_evicted", 16'd2, 1'b0, 16'h0000, 1'b0);
        check_eq("t2_chk", 32'(chk_a), 4);
        check_eq("t2_pass_pre", 32'(pass_a), 0);
        pulse_done();
        check_eq("t2_fail", 32'(fail_a), 1);
        check_eq("t2_pass", 32'(pass_a), 0);

        // Test 3: in-place overwrite keeps the pointer at 0.
        do_reset();
        req(1'b0, 16'd3, 16'h000C);
        req(1'b0, 16'd3, 16'h000D);
        read_a("t3_rd3", 16'd3, 1'b1, 16'h000D, 1'b0);
        req(1'b0, 16'd7, 16'h0077);
        req(1'b0, 16'd8, 16'h0088);
        req(1'b0, 16'd9, 16'h0099);
        req(1'b0, 16'd10, 16'h00AA);
        read_a("t3_rd3_evicted", 16'd3, 1'b0, 16'h0000, 1'b0);
        read_a("t3_rd7_kept", 16'd7, 1'b1, 16'h0077, 1'b0);
        read_a("t3_rd10", 16'd10, 1'b1, 16'h00AA, 1'b0);
        check_eq("t3_err", 32'(err_a), 0);

        // Test 4: 2-bit error counter saturates at 3.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            read_a("t4_pulse", 16'h0099, 1'b1, 16'h1234, 1'b1);
            check_eq("t4_err", 32'(err_a), (i < 3) ? i + 1 : 3);
        end

        // Test 5: idle-based watchdog, 20 cycles after the last request.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            req(1'b0, 16'(r), 16'h0001);
            for (int k = 0; k < 9; k++) tick();
            check_eq("t5_no_tmo", 32'(tmo_a), 0);
        end
        req(1'b0, 16'd40, 16'h0001);
        for (int k = 0; k < 19; k++) tick();
        check_eq("t5_tmo_19", 32'(tmo_a), 0);
        tick();
        check_eq("t5_tmo_20", 32'(tmo_a), 1);
        check_eq("t5_fail",   32'(fail_a), 1);
        check_eq("t5_pass",   32'(pass_a), 0);

        // Test 6: latency 3, compares in flight across done_i, then mid-run reset.
        do_reset();
        req(1'b0, 16'd1, 16'h0011);
        mon_valid = 1'b1; mon_rw_n = 1'b1; mon_key = 16'd1;
        tick();
        mon_key = 16'd2;
        tick();
        mon_valid = 1'b0;
        pulse_done();
        dv_b = 1'b1; dval_b = 16'h0011;
        #1;
        check_eq("t6_rd1_pulse", 32'(pulse_b), 0);
        check_eq("t6_verdict_pending", 32'({pass_b, fail_b}), 0);
        tick();
        dv_b = 1'b1; dval_b = 16'h0000;
        #1;
        check_eq("t6_rd2_pulse", 32'(pulse_b), 1);
        tick();
        dv_b = 1'b0;
        check_eq("t6_chk",  32'(chk_b), 2);
        check_eq("t6_err",  32'(err_b), 1);
        check_eq("t6_fail", 32'(fail_b), 1);
        check_eq("t6_pass", 32'(pass_b), 0);
        req(1'b1, 16'd5, 16'h0000);
        dv_b = 1'b1; dval_b = 16'h5555;
        for (int k = 0; k < 3; k++) tick();
        check_eq("t6_done_ignored_chk", 32'(chk_b), 2);
        check_eq("t6_done_ignored_err", 32'(err_b), 1);
        dv_b = 1'b0;

        do_reset();
        req(1'b0, 16'd1, 16'h0011);
        req(1'b1, 16'd1, 16'h0000);
        dv_b = 1'b1; dval_b = 16'hDEAD;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t6_rst_outs", 32'({pulse_b, tmo_b, pass_b, fail_b}), 0);
        check_eq("t6_rst_err", 32'(err_b), 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq("t6_rst_no_stale_pulse", 32'(pulse_b), 0);
            tick();
        end
        check_eq("t6_rst_chk", 32'(chk_b), 0);
        dv_b = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
